// File: rtl/hiscore_table.sv
// Per-user high-score table: single-port RAM holding each player's best score,
// a register mirror exported to the display, and a leaderboard tracker.
module hiscore_table #(
    parameter int          NUM_USERS    = 6,
    parameter int          SCORE_W      = 8,
    parameter int          ID_W         = 3,
    parameter logic [3:0]  COMMIT_STATE = 4'b0100
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [SCORE_W-1:0]             score,
    input  logic [3:0]                     gameState,
    input  logic                           scoreReset,
    input  logic [ID_W-1:0]                user_ID,
    output logic [NUM_USERS*SCORE_W-1:0]   scores_flat,
    output logic [SCORE_W-1:0]             best_score,
    output logic [ID_W-1:0]                best_user,
    output logic                           new_record,
    output logic                           bad_id,
    output logic                           busy
);

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_RD     = 3'd2,
        ST_CMP    = 3'd3,
        ST_CLR    = 3'd4,
        ST_RESCAN = 3'd5
    } state_t;

    localparam int              IDW1    = ID_W + 1;
    localparam logic [ID_W:0]   NUM_U   = IDW1'(NUM_USERS);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_USERS - 1);

    state_t               state_r, next_state_s;
    logic                 prev_commit_r, prev_clr_r;
    logic                 commit_edge_s, clear_edge_s, id_ok_s;
    logic [ID_W-1:0]      cnt_r;
    logic [SCORE_W-1:0]   lat_score_r;
    logic [ID_W-1:0]      lat_id_r;
    logic [SCORE_W-1:0]   mem_r [NUM_USERS];
    logic [SCORE_W-1:0]   rdata_r;
    logic                 mem_we_s;
    logic [ID_W-1:0]      mem_addr_s;
    logic [SCORE_W-1:0]   mem_wdata_s;
    logic [SCORE_W-1:0]   mirror_r [NUM_USERS];
    logic [SCORE_W-1:0]   run_max_r;
    logic [ID_W-1:0]      run_user_r;
    logic [SCORE_W-1:0]   cur_entry_s;
    logic                 better_s, scan_gt_s;
    logic [SCORE_W-1:0]   best_score_r;
    logic [ID_W-1:0]      best_user_r;
    logic                 new_record_r, bad_id_r, busy_r;

    assign commit_edge_s = (gameState == COMMIT_STATE) && !prev_commit_r;
    assign clear_edge_s  = scoreReset && !prev_clr_r;
    assign id_ok_s       = ({1'b0, user_ID} < NUM_U);
    assign better_s      = (lat_score_r > rdata_r);
    assign cur_entry_s   = mirror_r[cnt_r];
    assign scan_gt_s     = (cur_entry_s > run_max_r);

    for (genvar k = 0; k < NUM_USERS; k++) begin : g_flat
        assign scores_flat[k*SCORE_W +: SCORE_W] = mirror_r[k];
    end

    assign best_score = best_score_r;
    assign best_user  = best_user_r;
    assign new_record = new_record_r;
    assign bad_id     = bad_id_r;
    assign busy       = busy_r;

    // Next-state logic; a clear edge outranks a simultaneous commit edge
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (cnt_r == LAST_ID) next_state_s = ST_IDLE;
                else                  next_state_s = ST_INIT;
            end
            ST_IDLE: begin
                if (clear_edge_s) begin
                    if (id_ok_s) next_state_s = ST_CLR;
                    else         next_state_s = ST_IDLE;
                end else if (commit_edge_s) begin
                    if (id_ok_s) next_state_s = ST_RD;
                    else         next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RD:  next_state_s = ST_CMP;
            ST_CMP: next_state_s = ST_IDLE;
            ST_CLR: begin
                if (lat_id_r == best_user_r) next_state_s = ST_RESCAN;
                else                         next_state_s = ST_IDLE;
            end
            ST_RESCAN: begin
                if (cnt_r == LAST_ID) next_state_s = ST_IDLE;
                else                  next_state_s = ST_RESCAN;
            end
            default: next_state_s = ST_INIT;
        endcase
    end

    // RAM port control: address, write enable and write data per state
    always_comb begin
        mem_we_s    = 1'b0;
        mem_addr_s  = lat_id_r;
        mem_wdata_s = {SCORE_W{1'b0}};
        case (state_r)
            ST_INIT: begin
                mem_we_s   = 1'b1;
                mem_addr_s = cnt_r;
            end
            ST_CMP: begin
                mem_we_s    = better_s;
                mem_wdata_s = lat_score_r;
            end
            ST_CLR:  mem_we_s = 1'b1;
            default: mem_we_s = 1'b0;
        endcase
    end

    // Single-port synchronous RAM; writes are suppressed in a reset cycle
    always_ff @(posedge clk) begin
        if (mem_we_s && !rst) begin
            mem_r[mem_addr_s] <= mem_wdata_s;
        end
        rdata_r <= mem_r[mem_addr_s];
    end

    // Control state, mirror, leaderboard and output pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_INIT;
            cnt_r         <= {ID_W{1'b0}};
            prev_commit_r <= 1'b0;
            prev_clr_r    <= 1'b0;
            lat_score_r   <= {SCORE_W{1'b0}};
            lat_id_r      <= {ID_W{1'b0}};
            run_max_r     <= {SCORE_W{1'b0}};
            run_user_r    <= {ID_W{1'b0}};
            best_score_r  <= {SCORE_W{1'b0}};
            best_user_r   <= {ID_W{1'b0}};
            new_record_r  <= 1'b0;
            bad_id_r      <= 1'b0;
            busy_r        <= 1'b1;
            for (int k = 0; k < NUM_USERS; k++) mirror_r[k] <= {SCORE_W{1'b0}};
        end else begin
            state_r       <= next_state_s;
            prev_commit_r <= (gameState == COMMIT_STATE);
            prev_clr_r    <= scoreReset;
            new_record_r  <= 1'b0;
            bad_id_r      <= 1'b0;
            busy_r        <= (next_state_s != ST_IDLE);
            case (state_r)
                ST_INIT: begin
                    if (cnt_r == LAST_ID) cnt_r <= {ID_W{1'b0}};
                    else                  cnt_r <= cnt_r + ID_W'(1);
                end
                ST_IDLE: begin
                    if (clear_edge_s) begin
                        lat_id_r <= user_ID;
                        bad_id_r <= !id_ok_s;
                    end else if (commit_edge_s) begin
                        lat_id_r    <= user_ID;
                        lat_score_r <= score;
                        bad_id_r    <= !id_ok_s;
                    end
                end
                ST_CMP: begin
                    if (better_s) begin
                        mirror_r[lat_id_r] <= lat_score_r;
                        new_record_r       <= 1'b1;
                        if (lat_score_r > best_score_r) begin
                            best_score_r <= lat_score_r;
                            best_user_r  <= lat_id_r;
                        end
                    end
                end
                ST_CLR: begin
                    mirror_r[lat_id_r] <= {SCORE_W{1'b0}};
                    cnt_r              <= {ID_W{1'b0}};
                    run_max_r          <= {SCORE_W{1'b0}};
                    run_user_r         <= {ID_W{1'b0}};
                end
                ST_RESCAN: begin
                    // Strictly-greater update keeps the lowest index on ties
                    if (scan_gt_s) begin
                        run_max_r  <= cur_entry_s;
                        run_user_r <= cnt_r;
                    end
                    if (cnt_r == LAST_ID) begin
                        cnt_r        <= {ID_W{1'b0}};
                        best_score_r <= scan_gt_s ? cur_entry_s : run_max_r;
                        best_user_r  <= scan_gt_s ? cnt_r : run_user_r;
                    end else begin
                        cnt_r <= cnt_r + ID_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hiscore_table.sv
// Directed, table-driven bench for hiscore_table with hand-computed expectations.
module tb_hiscore_table;

    localparam int NU = 6;
    localparam int SW = 8;
    localparam int IW = 3;
    localparam logic [3:0] CS = 4'b0100;

    logic                clk = 1'b0;
    logic                rst;
    logic [SW-1:0]       score;
    logic [3:0]          gameState;
    logic                scoreReset;
    logic [IW-1:0]       user_ID;
    logic [NU*SW-1:0]    scores_flat;
    logic [SW-1:0]       best_score;
    logic [IW-1:0]       best_user;
    logic                new_record, bad_id, busy;

    int checks = 0;
    int errors = 0;

    hiscore_table #(.NUM_USERS(NU), .SCORE_W(SW), .ID_W(IW), .COMMIT_STATE(CS)) dut (
        .clk(clk), .rst(rst), .score(score), .gameState(gameState),
        .scoreReset(scoreReset), .user_ID(user_ID), .scores_flat(scores_flat),
        .best_score(best_score), .best_user(best_user), .new_record(new_record),
        .bad_id(bad_id), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_clr;
        logic [2:0]  id;
        logic [7:0]  sc;
        int          eid;
        logic [7:0]  e_entry;
        logic [7:0]  e_best;
        logic [2:0]  e_user;
        int          e_nr;
        int          e_bad;
        int          e_busy;
    } vec_t;

    vec_t vecs[16];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] entry(input int k);
        return scores_flat[k*SW +: SW];
    endfunction

    // Apply one edge, then run until the FSM is idle again, counting pulses
    task automatic run_op(input logic is_clr, input logic [2:0] id, input logic [7:0] sc,
                          output int nr, output int bad, output int bsy);
        bit done;
        nr = 0; bad = 0; bsy = 0; done = 1'b0;
        user_ID = id;
        score   = sc;
        if (is_clr) scoreReset = 1'b1;
        else        gameState  = CS;
        for (int i = 0; i < 40; i++) begin
            step();
            if (i == 0) begin
                scoreReset = 1'b0;
                gameState  = 4'd0;
            end
            nr  += int'(new_record);
            bad += int'(bad_id);
            bsy += int'(busy);
            if (!busy && i >= 1) begin
                done = 1'b1;
                break;
            end
        end
        check("op_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        int nr, bad, bsy;
        vecs[0]  = '{1'b0, 3'd3, 8'h1B, 3, 8'h1B, 8'h1B, 3'd3, 1, 0, 2};
        vecs[1]  = '{1'b0, 3'd1, 8'hC8, 1, 8'hC8, 8'hC8, 3'd1, 1, 0, 2};
        vecs[2]  = '{1'b0, 3'd5, 8'hE5, 5, 8'hE5, 8'hE5, 3'd5, 1, 0, 2};
        vecs[3]  = '{1'b0, 3'd1, 8'h08, 1, 8'hC8, 8'hE5, 3'd5, 0, 0, 2};
        vecs[4]  = '{1'b0, 3'd1, 8'hC8, 1, 8'hC8, 8'hE5, 3'd5, 0, 0, 2};
        vecs[5]  = '{1'b0, 3'd7, 8'h55, 5, 8'hE5, 8'hE5, 3'd5, 0, 1, 0};
        vecs[6]  = '{1'b1, 3'd3, 8'h00, 3, 8'h00, 8'hE5, 3'd5, 0, 0, 1};
        vecs[7]  = '{1'b1, 3'd5, 8'h00, 5, 8'h00, 8'hC8, 3'd1, 0, 0, 7};
        vecs[8]  = '{1'b0, 3'd3, 8'hC8, 3, 8'hC8, 8'hC8, 3'd1, 1, 0, 2};
        vecs[9]  = '{1'b0, 3'd4, 8'hC8, 4, 8'hC8, 8'hC8, 3'd1, 1, 0, 2};
        vecs[10] = '{1'b1, 3'd1, 8'h00, 1, 8'h00, 8'hC8, 3'd3, 0, 0, 7};
        vecs[11] = '{1'b1, 3'd6, 8'h00, 3, 8'hC8, 8'hC8, 3'd3, 0, 1, 0};
        vecs[12] = '{1'b1, 3'd3, 8'h00, 3, 8'h00, 8'hC8, 3'd4, 0, 0, 7};
        vecs[13] = '{1'b1, 3'd4, 8'h00, 4, 8'h00, 8'h00, 3'd0, 0, 0, 7};
        vecs[14] = '{1'b0, 3'd0, 8'hFF, 0, 8'hFF, 8'hFF, 3'd0, 1, 0, 2};
        vecs[15] = '{1'b1, 3'd0, 8'h00, 0, 8'h00, 8'h00, 3'd0, 0, 0, 7};

        rst = 1'b1; score = 8'h00; gameState = 4'd0; scoreReset = 1'b0; user_ID = 3'd0;
        step(); step();
        rst = 1'b0;
        for (int i = 0; i < NU - 1; i++) step();
        check("init_busy_high", 32'(busy), 32'd1);
        step();
        check("init_busy_low", 32'(busy), 32'd0);
        check("init_flat", 32'(scores_flat), 32'd0);
        check("init_best_score", 32'(best_score), 32'd0);
        check("init_best_user", 32'(best_user), 32'd0);

        for (int v = 0; v < 16; v++) begin
            run_op(vecs[v].is_clr, vecs[v].id, vecs[v].sc, nr, bad, bsy);
            check($sformatf("v%0d_entry", v), 32'(entry(vecs[v].eid)), 32'(vecs[v].e_entry));
            check($sformatf("v%0d_best", v), 32'(best_score), 32'(vecs[v].e_best));
            check($sformatf("v%0d_user", v), 32'(best_user), 32'(vecs[v].e_user));
            check($sformatf("v%0d_newrec", v), 32'(nr), 32'(vecs[v].e_nr));
            check($sformatf("v%0d_badid", v), 32'(bad), 32'(vecs[v].e_bad));
            check($sformatf("v%0d_busy", v), 32'(bsy), 32'(vecs[v].e_busy));
        end

        // Held commit level must commit exactly once
        nr = 0;
        user_ID = 3'd2; score = 8'h40; gameState = CS;
        for (int i = 0; i < 10; i++) begin step(); nr += int'(new_record); end
        gameState = 4'd0;
        for (int i = 0; i < 4; i++) begin step(); nr += int'(new_record); end
        check("hold_newrec", 32'(nr), 32'd1);
        check("hold_entry2", 32'(entry(2)), 32'h40);
        check("hold_best", {24'd0, best_score}, 32'h40);
        check("hold_user", 32'(best_user), 32'd2);

        // Simultaneous clear and commit: clear only, inputs held high
        nr = 0; bsy = 0;
        user_ID = 3'd2; score = 8'h90; gameState = CS; scoreReset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(); nr += int'(new_record); bsy += int'(busy);
        end
        gameState = 4'd0; scoreReset = 1'b0;
        step(); step();
        check("both_entry2", 32'(entry(2)), 32'd0);
        check("both_newrec", 32'(nr), 32'd0);
        check("both_busy", 32'(bsy), 32'd7);
        check("both_best", 32'(best_score), 32'd0);

        // An edge arriving while busy is dropped
        user_ID = 3'd1; score = 8'h30; gameState = CS;
        step();
        gameState = 4'd0;
        step();
        user_ID = 3'd3; score = 8'h50; gameState = CS;
        step();
        gameState = 4'd0;
        step(); step(); step();
        check("busy_drop_e1", 32'(entry(1)), 32'h30);
        check("busy_drop_e3", 32'(entry(3)), 32'd0);

        // Reset in the middle of a rescan, then prove the RAM was re-zeroed
        run_op(1'b0, 3'd4, 8'h77, nr, bad, bsy);
        check("pre_rst_best", 32'(best_score), 32'h77);
        user_ID = 3'd4; scoreReset = 1'b1;
        step();
        scoreReset = 1'b0;
        step(); step(); step();
        check("mid_rescan_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_flat", 32'(scores_flat), 32'd0);
        check("rst_best", 32'(best_score), 32'd0);
        for (int i = 0; i < NU; i++) step();
        check("rst_idle", 32'(busy), 32'd0);
        run_op(1'b0, 3'd1, 8'h05, nr, bad, bsy);
        check("post_rst_newrec", 32'(nr), 32'd1);
        check("post_rst_entry1", 32'(entry(1)), 32'h05);
        check("post_rst_user", 32'(best_user), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
